uart_tx_fifo: RTL and testbench

//  8N1 UART transmitter, the transmit side of the board UART link; pairs with the uart RX path.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_tx_fifo_buf.sv | 61 ++++++
 rtl/uart_tx_fifo.sv | 140 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit FSM state encoding
// Optional UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

  localparam logic UART_IDLE_LEVEL      = 1'b1;
  localparam int   DATA_BITS            = 8;
  localparam int   DEFAULT_DELAY_FRAMES = 234;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// rtl/uart_tx_fifo_buf.sv - synchronous FIFO holding bytes waiting to be serialised
// Head entry is visible combinationally on pop_data_o; full/empty derive from the registered count.
module uart_tx_fifo_buf #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == FULL_COUNT);
  assign empty_o    = (count_q == '0);
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-fed 8N1 UART transmitter, LSB first, registered serial output
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit between data and stop).
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(DELAY_FRAMES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY_FRAMES - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 uart_tx_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  logic                 fifo_full, fifo_empty;
  logic                 pop, bit_done;
  logic [DATA_BITS-1:0] head;

  assign bit_done = (cnt_q == CNT_LAST);
  // Pop from IDLE, or at the end of a stop bit so back-to-back frames have no gap.
  assign pop = !fifo_empty &&
               ((state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done));

  uart_tx_fifo_buf #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tx_valid),
    .push_data_i (tx_data),
    .pop_i       (pop),
    .pop_data_o  (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign uart_tx  = uart_tx_q;
  assign busy     = (state_q != TX_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      uart_tx_q <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= bit_done ? '0 : cnt_q + CW'(1);
      case (state_q)
        TX_IDLE: begin
          cnt_q     <= '0;
          uart_tx_q <= UART_IDLE_LEVEL;
          if (pop) begin
            shift_q   <= head;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^head;
`endif
            state_q   <= TX_START;
            uart_tx_q <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_done) begin
            state_q   <= TX_DATA;
            bit_idx_q <= '0;
            uart_tx_q <= shift_q[0];
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q   <= TX_PARITY;
              uart_tx_q <= parity_q;
`else
              state_q   <= TX_STOP;
              uart_tx_q <= UART_IDLE_LEVEL;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              uart_tx_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_done) begin
            state_q   <= TX_STOP;
            uart_tx_q <= UART_IDLE_LEVEL;
          end
        end
`endif
        TX_STOP: begin
          if (bit_done) begin
            if (pop) begin
              shift_q   <= head;
`ifdef UART_TX_PARITY_EN
              parity_q  <= ^head;
`endif
              state_q   <= TX_START;
              uart_tx_q <= 1'b0;
            end else begin
              state_q   <= TX_IDLE;
              uart_tx_q <= UART_IDLE_LEVEL;
            end
          end
        end
        default: begin
          state_q   <= TX_IDLE;
          uart_tx_q <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo
// Honours UART_TX_PARITY_EN for 8E1 framing.
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int D     = 8;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * D;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, uart_tx, busy;
  logic [2:0] fifo_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_cnt = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         clean;
  } frame_t;

  frame_t     rxq[$];
  logic [7:0] expq[$];

  uart_tx_fifo #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge rst) rst_cnt = rst_cnt + 1;

  // Line level expected in bit slot j of a frame carrying byte b.
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == NB - 1) return 1'b1;
    return ^b;
  endfunction

  // Line decoder: captures every complete frame, noting its start cycle and framing validity.
  initial begin : monitor
    logic   prev;
    logic   s[FR];
    int     start, rc;
    bit     aborted;
    frame_t f;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
      end else if (prev && !uart_tx) begin
        start = cyc;
        rc = rst_cnt;
        aborted = 1'b0;
        s[0] = uart_tx;
        for (int k = 1; k < FR; k++) begin
          @(negedge clk);
          if (rst || rst_cnt != rc) begin
            aborted = 1'b1;
            break;
          end
          s[k] = uart_tx;
        end
        if (!aborted) begin
          f.start = start;
          f.clean = 1'b1;
          for (int j = 0; j < NB; j++)
            for (int k = 1; k < D; k++)
              if (s[j*D+k] !== s[j*D]) f.clean = 1'b0;
          if (s[0] !== 1'b0 || s[FR-1] !== 1'b1) f.clean = 1'b0;
          for (int i = 0; i < 8; i++) f.data[i] = s[(i+1)*D];
`ifdef UART_TX_PARITY_EN
          if (s[9*D] !== ^f.data) f.clean = 1'b0;
`endif
          rxq.push_back(f);
          prev = s[FR-1];
        end else begin
          prev = 1'b1;
        end
      end else begin
        prev = uart_tx;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int edge_n);
    int g = 0;
    tx_valid = 1'b1;
    tx_data  = b;
    while (!tx_ready && g < 20*FR) begin
      @(negedge clk);
      g++;
    end
    if (!tx_ready) begin
      total++; bad++;
      $display("FAIL push_timeout tx_ready=%b required=1", tx_ready);
    end
    @(negedge clk);
    edge_n   = cyc;
    tx_valid = 1'b0;
    expq.push_back(b);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 20*FR) begin
      @(negedge clk);
      g++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle_timeout busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle uart_tx=%b busy=%b exp=1/0", uart_tx, busy);
    end
  endtask

  task automatic test_single();
    int n;
    logic [7:0] b = 8'h41;
    rxq.delete(); expq.delete();
    push_byte(b, n);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL single_pre_start got=%b exp=1", uart_tx); end
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", fifo_count); end
    for (int k = 0; k < FR; k++) begin
      @(negedge clk);
      total++;
      if (uart_tx !== exp_bit(b, k / D)) begin
        bad++; $display("FAIL single_wave off=%0d got=%b exp=%b", k, uart_tx, exp_bit(b, k / D));
      end
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_last got=%b exp=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end got=%b exp=0", busy); end
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL single_frames got=%0d exp=1", rxq.size()); end
    else begin
      total++; if (rxq[0].start != n + 1) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", rxq[0].start, n + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    int n0, n1, g;
    for (int p = 0; p < 3; p++) begin
      a = (p == 0) ? 8'h55 : 8'($urandom);
      b = (p == 0) ? 8'hAA : 8'($urandom);
      wait_idle();
      rxq.delete(); expq.delete();
      push_byte(a, n0);
      push_byte(b, n1);
      g = 0;
      while (cyc < n0 + 2*FR && g < 4*FR) begin @(negedge clk); g++; end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_last p=%0d got=%b exp=1", p, busy); end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end p=%0d got=%b exp=0", p, busy); end
      total++; if (rxq.size() != 2) begin bad++; $display("FAIL b2b_frames p=%0d got=%0d exp=2", p, rxq.size()); end
      else begin
        total++; if (rxq[0].data !== a || !rxq[0].clean) begin
          bad++; $display("FAIL b2b_first p=%0d got=%h clean=%0d exp=%h", p, rxq[0].data, rxq[0].clean, a);
        end
        total++; if (rxq[1].data !== b || !rxq[1].clean) begin
          bad++; $display("FAIL b2b_second p=%0d got=%h clean=%0d exp=%h", p, rxq[1].data, rxq[1].clean, b);
        end
        total++; if (rxq[1].start - rxq[0].start != FR) begin
          bad++; $display("FAIL b2b_gap p=%0d got=%0d exp=%0d", p, rxq[1].start - rxq[0].start, FR);
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] bytes[6];
    int i = 0;
    int g = 0;
    bit acc;
    bit saw_full = 1'b0;
    wait_idle();
    rxq.delete(); expq.delete();
    foreach (bytes[k]) bytes[k] = 8'($urandom);
    tx_valid = 1'b1;
    while (i < 6 && g < 20*FR) begin
      total++;
      if (tx_ready !== (fifo_count != 3'(DEPTH))) begin
        bad++; $display("FAIL full_ready got=%b count=%0d", tx_ready, fifo_count);
      end
      if (tx_ready) begin
        tx_data = bytes[i];
      end else begin
        tx_data = 8'($urandom);
        saw_full = 1'b1;
      end
      acc = tx_ready;
      @(negedge clk);
      g++;
      if (acc) i++;
    end
    tx_valid = 1'b0;
    total++; if (!saw_full) begin bad++; $display("FAIL full_never_full got=0 exp=1"); end
    g = 0;
    while (rxq.size() < 6 && g < 8*FR) begin @(negedge clk); g++; end
    total++; if (rxq.size() != 6) begin bad++; $display("FAIL full_frames got=%0d exp=6", rxq.size()); end
    else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (rxq[k].data !== bytes[k] || !rxq[k].clean) begin
          bad++; $display("FAIL full_order k=%0d got=%h clean=%0d exp=%h", k, rxq[k].data, rxq[k].clean, bytes[k]);
        end
        if (k > 0) begin
          total++;
          if (rxq[k].start - rxq[k-1].start != FR) begin
            bad++; $display("FAIL full_gap k=%0d got=%0d exp=%0d", k, rxq[k].start - rxq[k-1].start, FR);
          end
        end
      end
    end
  endtask

  task automatic test_push_pop();
    logic [7:0] b[4];
    int n0, n1, n2, g;
    wait_idle();
    rxq.delete(); expq.delete();
    foreach (b[k]) b[k] = 8'($urandom);
    push_byte(b[0], n0);
    push_byte(b[1], n1);
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL pp_first_pop got=%0d exp=1", fifo_count); end
    push_byte(b[2], n2);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_count2 got=%0d exp=2", fifo_count); end
    while (cyc < n0 + FR) @(negedge clk);
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_before got=%0d exp=2", fifo_count); end
    tx_valid = 1'b1;
    tx_data  = b[3];
    @(negedge clk);
    tx_valid = 1'b0;
    total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_same_cycle got=%0d exp=2", fifo_count); end
    g = 0;
    while (cyc < n0 + 4*FR + 2 && g < 6*FR) begin @(negedge clk); g++; end
    total++; if (rxq.size() != 4) begin bad++; $display("FAIL pp_frames got=%0d exp=4", rxq.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (rxq[k].data !== b[k] || !rxq[k].clean || rxq[k].start != n0 + 1 + k*FR) begin
          bad++; $display("FAIL pp_frame k=%0d got=%h start=%0d exp=%h start=%0d",
                          k, rxq[k].data, rxq[k].start, b[k], n0 + 1 + k*FR);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a, c;
    int n0, n1, g;
    wait_idle();
    rxq.delete(); expq.delete();
    a = 8'($urandom) & 8'hF7;
    push_byte(a, n0);
    push_byte(8'($urandom), n1);
    push_byte(8'($urandom), n1);
    while (cyc < n0 + 1 + 4*D + 3) @(negedge clk);
    total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL rmid_bit3 got=%b exp=0", uart_tx); end
    #2 rst = 1'b1;
    #1;
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL rmid_uart_tx got=%b exp=1", uart_tx); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rmid_count got=%0d exp=0", fifo_count); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", tx_ready); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (FR + 4) @(negedge clk);
    total++; if (rxq.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL rmid_discard frames=%0d busy=%b exp=0/0", rxq.size(), busy);
    end
    c = 8'($urandom);
    push_byte(c, n0);
    g = 0;
    while (cyc < n0 + FR + 1 && g < 2*FR) begin @(negedge clk); g++; end
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL rmid_after_frames got=%0d exp=1", rxq.size()); end
    else begin
      total++; if (rxq[0].data !== c || !rxq[0].clean || rxq[0].start != n0 + 1) begin
        bad++; $display("FAIL rmid_after got=%h clean=%0d start=%0d exp=%h start=%0d",
                        rxq[0].data, rxq[0].clean, rxq[0].start, c, n0 + 1);
      end
    end
  endtask

  task automatic test_random();
    int n, gap;
    wait_idle();
    rxq.delete(); expq.delete();
    for (int k = 0; k < 16; k++) begin
      gap = (($urandom & 3) == 0) ? 0 : $urandom_range(0, 2*FR);
      repeat (gap) @(negedge clk);
      push_byte(8'($urandom), n);
    end
    wait_idle();
    repeat (2) @(negedge clk);
    total++; if (rxq.size() != expq.size()) begin
      bad++; $display("FAIL rand_frames got=%0d exp=%0d", rxq.size(), expq.size());
    end else begin
      for (int k = 0; k < expq.size(); k++) begin
        total++;
        if (rxq[k].data !== expq[k] || !rxq[k].clean) begin
          bad++; $display("FAIL rand_frame k=%0d got=%h clean=%0d exp=%h", k, rxq[k].data, rxq[k].clean, expq[k]);
        end
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int n;
    wait_idle();
    rxq.delete(); expq.delete();
    push_byte(8'h07, n);
    while (cyc < n + 1 + 9*D + 2) @(negedge clk);
    total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL par_bit got=%b exp=1", uart_tx); end
    while (cyc < n + FR) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL par_busy_last got=%b exp=1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL par_busy_end got=%b exp=0", busy); end
    total++; if (rxq.size() != 1) begin bad++; $display("FAIL par_frames got=%0d exp=1", rxq.size()); end
    else begin
      total++; if (rxq[0].data !== 8'h07 || !rxq[0].clean) begin
        bad++; $display("FAIL par_frame got=%h clean=%0d exp=07", rxq[0].data, rxq[0].clean);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_push_pop();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
